// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, SRAM write-enable codes, FSM states and helpers for the LSU
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] WEN_READ = 4'b0000;
   localparam logic [3:0] WEN_BYTE = 4'b0001;
   localparam logic [3:0] WEN_HALF = 4'b0011;
   localparam logic [3:0] WEN_WORD = 4'b1111;

   typedef enum logic [1:0] {IDLE, ACCESS, LOAD_WAIT, RESP} state_t;

   // Only legal store funct3 values (0..2) ever reach this, so the low two bits suffice
   function automatic logic [3:0] store_wen(input logic [2:0] funct3);
      return funct3[1:0] == 2'b00 ? WEN_BYTE : funct3[1:0] == 2'b01 ? WEN_HALF : WEN_WORD;
   endfunction

endpackage

// File: rtl/lsu_ctrl_load_align.sv
// load_align: request legality check and load-data byte/half select with sign/zero extension
//   chk_we, chk_funct3, chk_addr : incoming request fields to classify
//   chk_illegal                  : 1 = bad funct3 or disallowed misalignment
//   funct3, raw                  : registered load funct3 and raw SRAM word
//   data                         : extended 32-bit load result
module load_align
   import lsu_pkg::*;
#(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        chk_we,
   input  logic [2:0]  chk_funct3,
   input  logic [1:0]  chk_addr,
   output logic        chk_illegal,
   input  logic [2:0]  funct3,
   input  logic [31:0] raw,
   output logic [31:0] data
);

   function automatic logic illegal(input logic we, input logic [2:0] f3, input logic [1:0] a);
      logic bad_f3, misaligned;
      bad_f3     = we ? (f3 > F3_W) : (f3 == 3'b011 || f3[2:1] == 2'b11);
      misaligned = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
      return bad_f3 || (!ALLOW_MISALIGNED && misaligned);
   endfunction

   // The SRAM returns the word starting at the request byte address, so the
   // addressed byte/half is always in the low lanes: no shifting needed here.
   always_comb begin
      chk_illegal = illegal(chk_we, chk_funct3, chk_addr);
      data = funct3 == F3_B  ? {{24{raw[7]}}, raw[7:0]}   :
             funct3 == F3_H  ? {{16{raw[15]}}, raw[15:0]} :
             funct3 == F3_BU ? {24'h0, raw[7:0]}          :
             funct3 == F3_HU ? {16'h0, raw[15:0]}         : raw;
   end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding RV32I load/store controller in front of a byte-addressed SRAM
//   clk, rst_n                       : clock, async active-low reset
//   req_valid/ready/we/funct3/addr/wdata : request handshake from execute
//   rsp_valid, rsp_rdata, rsp_err    : one-cycle completion pulse with extended load data / error
//   mem_w_en, mem_addr, mem_wdata    : SRAM control (0000 = read), byte address, write data
//   mem_rdata                        : registered SRAM read word
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W           = 16,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [3:0]        mem_w_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   state_t      state;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic        illegal;
   logic [31:0] load_data;
   logic        unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:ADDR_W];

   load_align #(.ALLOW_MISALIGNED(ALLOW_MISALIGNED)) u_align (
      .chk_we      (req_we),
      .chk_funct3  (req_funct3),
      .chk_addr    (req_addr[1:0]),
      .chk_illegal (illegal),
      .funct3      (funct3_q),
      .raw         (mem_rdata),
      .data        (load_data)
   );

   // mem_w_en is a register cleared by the async reset, so an abort during
   // ACCESS drops the write strobe immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         funct3_q  <= 3'b000;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
         mem_w_en  <= WEN_READ;
         mem_addr  <= '0;
         mem_wdata <= 32'h0;
      end else begin
         case (state)
            IDLE: if (req_valid && req_ready) begin
               we_q      <= req_we;
               funct3_q  <= req_funct3;
               mem_addr  <= req_addr[ADDR_W-1:0];
               mem_wdata <= req_wdata;
               req_ready <= 1'b0;
               if (illegal) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= 32'h0;
               end else begin
                  state    <= ACCESS;
                  mem_w_en <= req_we ? store_wen(req_funct3) : WEN_READ;
               end
            end
            ACCESS: begin
               mem_w_en <= WEN_READ;
               if (we_q) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= 32'h0;
               end else begin
                  state <= LOAD_WAIT;
               end
            end
            LOAD_WAIT: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= load_data;
            end
            RESP: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl with a byte-addressed SRAM model
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata, mem_wdata;
   logic [3:0]  mem_w_en;
   logic [15:0] mem_addr;
   logic [31:0] mem_rdata = 32'h0;

   logic        m_req_ready, m_rsp_valid, m_rsp_err;
   logic [31:0] m_rsp_rdata, m_mem_wdata;
   logic [3:0]  m_mem_w_en;
   logic [15:0] m_mem_addr;

   logic [7:0]  mem [0:65535] = '{default: 8'h00};
   int          n_wr = 0;
   int          n_asrt = 0;
   int          n_fail = 0;
   int          wr0, pulses;
   logic [9:0]  vpat, rpat;

   always #5 clk = ~clk;

   // Strict-alignment DUT drives the SRAM model
   lsu_ctrl #(.ADDR_W(16), .ALLOW_MISALIGNED(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Misalignment-tolerant DUT sees the same requests and read data
   lsu_ctrl #(.ADDR_W(16), .ALLOW_MISALIGNED(1'b1)) dut_mis (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(m_req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(m_rsp_valid), .rsp_rdata(m_rsp_rdata), .rsp_err(m_rsp_err),
      .mem_w_en(m_mem_w_en), .mem_addr(m_mem_addr), .mem_wdata(m_mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_w_en == 4'b0000)
         mem_rdata <= {mem[mem_addr + 16'd3], mem[mem_addr + 16'd2], mem[mem_addr + 16'd1], mem[mem_addr]};
      else
         n_wr <= n_wr + 1;
      for (int i = 0; i < 4; i++)
         if (mem_w_en[i]) mem[mem_addr + 16'(i)] <= mem_wdata[8*i +: 8];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                       input logic [31:0] exp_rd, input logic exp_err, input logic [3:0] exp_wen);
      int lat, w0;
      @(negedge clk);
      chk({tag, " ready_idle"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
      w0 = n_wr;
      @(negedge clk);
      req_valid = 1'b0;
      chk({tag, " ready_busy"}, 32'(req_ready), 32'd0);
      chk({tag, " w_en"}, 32'(mem_w_en), 32'(exp_wen));
      if (!exp_err) chk({tag, " addr"}, 32'(mem_addr), 32'(a[15:0]));
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " rdata"}, rsp_rdata, exp_rd);
      chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
      @(negedge clk);
      chk({tag, " pulse_end"}, 32'(rsp_valid), 32'd0);
      chk({tag, " writes"}, 32'(n_wr - w0), 32'(exp_wen != 4'b0000));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst req_ready", 32'(req_ready), 32'd1);
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst rsp_rdata", rsp_rdata, 32'h0);
      chk("rst rsp_err", 32'(rsp_err), 32'd0);
      chk("rst mem_w_en", 32'(mem_w_en), 32'd0);
      chk("rst mem_addr", 32'(mem_addr), 32'd0);
      chk("rst mem_wdata", mem_wdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      xact("SW 10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 4'b1111);
      xact("LW 10",  1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 4'b0000);
      xact("LB 13",  1'b0, 3'b000, 32'h13, 32'h0, 3, 32'hFFFFFFDE, 1'b0, 4'b0000);
      xact("LBU 13", 1'b0, 3'b100, 32'h13, 32'h0, 3, 32'h000000DE, 1'b0, 4'b0000);
      xact("LH 12",  1'b0, 3'b001, 32'h12, 32'h0, 3, 32'hFFFFDEAD, 1'b0, 4'b0000);
      xact("LHU 10", 1'b0, 3'b101, 32'h10, 32'h0, 3, 32'h0000BEEF, 1'b0, 4'b0000);
      xact("SB 20",  1'b1, 3'b000, 32'h20, 32'h12345678, 2, 32'h0, 1'b0, 4'b0001);
      xact("LW 20",  1'b0, 3'b010, 32'h20, 32'h0, 3, 32'h00000078, 1'b0, 4'b0000);
      xact("SH 22",  1'b1, 3'b001, 32'h22, 32'h0000CAFE, 2, 32'h0, 1'b0, 4'b0011);
      xact("LW 20b", 1'b0, 3'b010, 32'h20, 32'h0, 3, 32'hCAFE0078, 1'b0, 4'b0000);

      xact("LW 11 mis", 1'b0, 3'b010, 32'h11, 32'h0, 1, 32'h0, 1'b1, 4'b0000);
      @(negedge clk);
      chk("LW 11 tolerant valid", 32'(m_rsp_valid), 32'd1);
      chk("LW 11 tolerant err", 32'(m_rsp_err), 32'd0);
      chk("LW 11 tolerant rdata", m_rsp_rdata, 32'h00DEADBE);

      xact("LH 11 mis", 1'b0, 3'b001, 32'h11, 32'h0, 1, 32'h0, 1'b1, 4'b0000);
      @(negedge clk);
      chk("LH 11 tolerant valid", 32'(m_rsp_valid), 32'd1);
      chk("LH 11 tolerant rdata", m_rsp_rdata, 32'hFFFFADBE);

      xact("LD f3=011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1, 4'b0000);
      chk("LD f3=011 tolerant err", 32'(m_rsp_err), 32'd1);
      xact("ST f3=100", 1'b1, 3'b100, 32'h40, 32'h99999999, 1, 32'h0, 1'b1, 4'b0000);
      xact("LW 40", 1'b0, 3'b010, 32'h40, 32'h0, 3, 32'h0, 1'b0, 4'b0000);

      vpat = 10'b0100100010;
      rpat = 10'b1001000100;
      pulses = 0;
      @(negedge clk);
      chk("b2b ready0", 32'(req_ready), 32'd1);
      wr0 = n_wr;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h50; req_wdata = 32'h11223344;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         chk($sformatf("b2b valid n%0d", i), 32'(rsp_valid), 32'(vpat[i-1]));
         chk($sformatf("b2b ready n%0d", i), 32'(req_ready), 32'(rpat[i-1]));
         if (rsp_valid) pulses++;
         if (i == 1) req_we = 1'b0;
         if (i == 4) begin
            req_we = 1'b1; req_addr = 32'h54; req_wdata = 32'h55667788;
         end
         if (i == 6) chk("b2b lw data", rsp_rdata, 32'h11223344);
         if (i == 8) req_valid = 1'b0;
      end
      chk("b2b pulses", 32'(pulses), 32'd3);
      chk("b2b writes", 32'(n_wr - wr0), 32'd2);
      xact("LW 54", 1'b0, 3'b010, 32'h54, 32'h0, 3, 32'h55667788, 1'b0, 4'b0000);

      xact("SW 30 pre", 1'b1, 3'b010, 32'h30, 32'h0BADF00D, 2, 32'h0, 1'b0, 4'b1111);
      @(negedge clk);
      wr0 = n_wr;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'hAAAAAAAA;
      @(posedge clk);
      #2;
      chk("abort w_en before", 32'(mem_w_en), 32'hF);
      rst_n = 1'b0;
      #1;
      req_valid = 1'b0;
      chk("abort req_ready", 32'(req_ready), 32'd1);
      chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort rsp_rdata", rsp_rdata, 32'h0);
      chk("abort rsp_err", 32'(rsp_err), 32'd0);
      chk("abort mem_w_en", 32'(mem_w_en), 32'd0);
      chk("abort mem_addr", 32'(mem_addr), 32'd0);
      chk("abort mem_wdata", mem_wdata, 32'h0);
      @(posedge clk);
      #1;
      chk("abort held w_en", 32'(mem_w_en), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort no write", 32'(n_wr - wr0), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("abort no rsp %0d", i), 32'(rsp_valid), 32'd0);
      end
      xact("LW 30 after abort", 1'b0, 3'b010, 32'h30, 32'h0, 3, 32'h0BADF00D, 1'b0, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
